// File: rtl/bsg_rr_arb_pkg.sv
// Shared types for the round-robin packet arbiter.
package bsg_rr_arb_pkg;

  typedef enum logic {eIdle, eLocked} bsg_rr_arb_state_e;

endpackage

// File: rtl/bsg_arb_rr_select.sv
// Combinational rotating-priority encoder: first request at or after ptr_i, with wrap.
module bsg_arb_rr_select #(
  parameter int unsigned els_p     = 4,
  parameter int unsigned lg_els_lp = $clog2(els_p)
) (
  input  logic [els_p-1:0]     reqs_i,
  input  logic [lg_els_lp-1:0] ptr_i,
  output logic [els_p-1:0]     grant_o,
  output logic [lg_els_lp-1:0] id_o,
  output logic                 v_o
);

  int unsigned idx;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    v_o     = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < els_p; i++) begin
      idx = (32'(ptr_i) + i) % els_p;
      if (!v_o && reqs_i[idx]) begin
        grant_o[idx] = 1'b1;
        id_o         = idx[lg_els_lp-1:0];
        v_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_rr_packet_arbiter.sv
// Round-robin arbiter with packet locking and a one-entry registered output stage.
module bsg_rr_packet_arbiter
  import bsg_rr_arb_pkg::*;
#(
  parameter int unsigned els_p     = 4,
  parameter int unsigned width_p   = 32,
  parameter int unsigned lg_els_lp = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   data_i,
  input  logic [els_p-1:0]           last_i,
  output logic [els_p-1:0]           ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic                       last_o,
  input  logic                       ready_i,
  output logic                       lock_o,
  output logic [lg_els_lp-1:0]       owner_o
);

  bsg_rr_arb_state_e      state_q, state_d;
  logic [lg_els_lp-1:0]   rr_ptr_q, rr_ptr_d;
  logic [lg_els_lp-1:0]   owner_q, owner_d;
  logic                   v_q, v_d;
  logic [width_p-1:0]     data_q, data_d;
  logic                   last_q, last_d;

  logic [els_p-1:0]       sel_grant;
  logic [lg_els_lp-1:0]   sel_id;
  logic                   sel_v;
  logic [els_p-1:0]       owner_oh;
  logic [els_p-1:0]       gnt_oh;
  logic [lg_els_lp-1:0]   win_id;
  logic [lg_els_lp-1:0]   win_next;
  logic [width_p-1:0]     mux_data;
  logic                   mux_last;
  logic                   can_accept;
  logic                   xfer;

  bsg_arb_rr_select #(
    .els_p     (els_p),
    .lg_els_lp (lg_els_lp)
  ) u_select (
    .reqs_i  (v_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (sel_grant),
    .id_o    (sel_id),
    .v_o     (sel_v)
  );

  assign can_accept = ~v_q | ready_i;

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  // While locked, only the owner may be granted regardless of other requests.
  always_comb begin
    if (state_q == eLocked) begin
      gnt_oh = owner_oh;
      win_id = owner_q;
    end else begin
      gnt_oh = sel_v ? sel_grant : '0;
      win_id = sel_id;
    end
  end

  assign ready_o  = gnt_oh & {els_p{can_accept}};
  assign xfer     = |(ready_o & v_i);
  assign mux_last = |(last_i & gnt_oh);
  assign win_next = (win_id == lg_els_lp'(els_p - 1)) ? '0 : win_id + 1'b1;

  always_comb begin
    mux_data = '0;
    for (int unsigned k = 0; k < els_p; k++) begin
      mux_data |= data_i[k*width_p +: width_p] & {width_p{gnt_oh[k]}};
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (xfer) begin
      owner_d = win_id;
      if (mux_last) begin
        state_d  = eIdle;
        rr_ptr_d = win_next;
      end else begin
        state_d  = eLocked;
      end
    end
  end

  // Output stage drains and reloads in the same cycle when it can accept.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    last_d = last_q;
    if (can_accept) begin
      v_d = xfer;
      if (xfer) begin
        data_d = mux_data;
        last_d = mux_last;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= eIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      v_q      <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      v_q      <= v_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

  assign v_o     = v_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign lock_o  = (state_q == eLocked);
  assign owner_o = owner_q;

endmodule
